alu_sched: RTL and testbench

Sequencing controller for the shared 16-bit ALU. Two requesters (port 0 and port 1) submit operations through valid/ready handshakes. The block arbitrates round-robin, registers the operands, drives the combinational ALU, and captures the result. It owns the architectural status-flag register (Z, N, C, O), resolves conditional-branch opcodes from that stored register rather than through ALU feedback, and returns each result on a single response channel tagged with the originating port.

---
 rtl/alu_sched.sv | 162 ++++++++++++++++
 tb/tb_alu_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Sequencing controller for the shared 16-bit ALU: round-robin arbitration of two requesters,
// operand registering, multi-cycle EXEC timing, stored status flags and a tagged response.
module alu_sched #(
    parameter int unsigned MULDIV_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_opcode,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_opcode,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic [5:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    input  logic        alu_o,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic [3:0]  flags
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [3:0] MulDivLoad = 4'(MULDIV_CYCLES);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        rsp_id_q, rsp_id_d;
    logic [5:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic        err_q, err_d;
    logic [3:0]  flags_q, flags_d;

    logic        grant0, grant1;
    logic [5:0]  sel_op;
    logic        is_branch, is_undef, is_divzero, upd_flags, branch_flag;

    // On a tie the port that did not win last time is granted.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = !rst && (state_q == StIdle) && grant0;
    assign req1_ready = !rst && (state_q == StIdle) && grant1;
    assign sel_op     = grant1 ? req1_opcode : req0_opcode;

    assign is_branch  = (op_q >= 6'h12) && (op_q <= 6'h15);
    assign is_undef   = (op_q > 6'h18);
    assign is_divzero = ((op_q == 6'h03) || (op_q == 6'h04)) && (b_q == 16'h0000);
    assign upd_flags  = (op_q <= 6'h11) && (op_q != 6'h0D);

    always_comb begin
        branch_flag = 1'b0;
        case (op_q)
            6'h12:   branch_flag = flags_q[3];
            6'h13:   branch_flag = flags_q[2];
            6'h14:   branch_flag = flags_q[1];
            6'h15:   branch_flag = flags_q[0];
            default: branch_flag = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        err_d        = err_q;
        flags_d      = flags_q;
        unique case (state_q)
            StIdle: begin
                if (req0_ready || req1_ready) begin
                    op_d         = sel_op;
                    a_d          = grant1 ? req1_a : req0_a;
                    b_d          = grant1 ? req1_b : req0_b;
                    rsp_id_d     = grant1;
                    last_grant_d = grant1;
                    cnt_d        = ((sel_op >= 6'h02) && (sel_op <= 6'h04)) ? MulDivLoad : 4'd1;
                    state_d      = StExec;
                end
            end
            StExec: begin
                if (cnt_q <= 4'd1) begin
                    if (is_undef) begin
                        result_d = 16'h0000;
                    end else if (is_branch) begin
                        result_d = {15'b0, branch_flag};
                    end else begin
                        result_d = alu_result;
                    end
                    err_d = is_undef || is_divzero;
                    if (upd_flags) begin
                        flags_d = {alu_z, alu_n, alu_c, alu_o};
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            op_q         <= 6'h00;
            a_q          <= 16'h0000;
            b_q          <= 16'h0000;
            cnt_q        <= 4'd0;
            result_q     <= 16'h0000;
            err_q        <= 1'b0;
            flags_q      <= 4'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            err_q        <= err_d;
            flags_q      <= flags_d;
        end
    end

    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: a behavioural ALU drives the ALU port, and a transaction-level
// model predicts grants, latency, results, errors and flags for every accepted request.
module tb_alu_sched;

    localparam int MDC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [5:0]  req0_opcode, req1_opcode;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [5:0]  alu_opcode;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        alu_z, alu_n, alu_c, alu_o;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] rsp_result;
    logic [3:0]  flags;

    alu_sched #(.MULDIV_CYCLES(MDC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_opcode(req0_opcode),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_opcode(req1_opcode),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .alu_c      (alu_c),
        .alu_o      (alu_o),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {result, z, n, c, o}.
    function automatic logic [19:0] alu_fn(input logic [5:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [16:0] w;
        logic [31:0] m;
        logic [15:0] r;
        logic        c, o;
        c = 1'b0;
        o = 1'b0;
        w = 17'h0;
        m = 32'h0;
        case (op)
            6'h00: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[15:0];
                c = w[16];
                o = (a[15] == b[15]) && (r[15] != a[15]);
            end
            6'h01: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[15:0];
                c = w[16];
                o = (a[15] != b[15]) && (r[15] != a[15]);
            end
            6'h02: begin
                m = {16'h0, a} * {16'h0, b};
                r = m[15:0];
                c = |m[31:16];
                o = c;
            end
            6'h03:   r = (b == 16'h0) ? 16'hFFFF : a / b;
            6'h04:   r = (b == 16'h0) ? 16'hFFFF : a % b;
            6'h05:   r = a & b;
            6'h06:   r = a | b;
            6'h07:   r = a ^ b;
            6'h08:   r = ~a;
            6'h09:   r = a << b[3:0];
            6'h0A:   r = a >> b[3:0];
            6'h0D:   r = b;
            default: begin
                r = (a ^ {10'h0, op}) + b;
                c = a[0];
                o = b[15];
            end
        endcase
        return {r, (r == 16'h0), r[15], c, o};
    endfunction

    always_comb {alu_result, alu_z, alu_n, alu_c, alu_o} = alu_fn(alu_opcode, alu_a, alu_b);

    typedef struct {
        logic        id;
        logic [15:0] res;
        logic        err;
        logic [3:0]  fl;
        int          due;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    logic [3:0] flags_m = 4'h0;
    logic lg_m = 1'b1;
    logic busy = 1'b0;
    logic in_resp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Predict the outcome of an accepted request from the architectural rules.
    function automatic exp_t predict(input logic id, input logic [5:0] op, input logic [15:0] a,
                                     input logic [15:0] b, input int now);
        exp_t e;
        logic [19:0] f;
        int k;
        f = alu_fn(op, a, b);
        k = (op >= 6'h02 && op <= 6'h04) ? MDC : 1;
        e.id  = id;
        e.err = 1'b0;
        if (op >= 6'h12 && op <= 6'h15) begin
            e.res = {15'b0, flags_m[3 - int'(op - 6'h12)]};
        end else if (op > 6'h18) begin
            e.res = 16'h0;
            e.err = 1'b1;
        end else begin
            e.res = f[19:4];
        end
        if ((op == 6'h03 || op == 6'h04) && b == 16'h0) e.err = 1'b1;
        if (op <= 6'h11 && op != 6'h0D) flags_m = f[3:0];
        e.fl  = flags_m;
        e.due = now + k + 1;
        return e;
    endfunction

    // Monitor: samples 2 time units after the driver, i.e. the values seen at the next edge.
    initial begin
        int   g;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst) begin
                chk("ready_in_rst", {30'h0, req0_ready, req1_ready}, 32'h0);
                flags_m = 4'h0;
                lg_m    = 1'b1;
                busy    = 1'b0;
                in_resp = 1'b0;
                q.delete();
            end else begin
                if (!busy) begin
                    g = -1;
                    if (req0_valid && req1_valid) g = lg_m ? 0 : 1;
                    else if (req0_valid) g = 0;
                    else if (req1_valid) g = 1;
                    chk("ready0", {31'h0, req0_ready}, {31'h0, (g == 0)});
                    chk("ready1", {31'h0, req1_ready}, {31'h0, (g == 1)});
                    chk("flags_idle", {28'h0, flags}, {28'h0, flags_m});
                    if (g == 0) q.push_back(predict(1'b0, req0_opcode, req0_a, req0_b, cyc));
                    if (g == 1) q.push_back(predict(1'b1, req1_opcode, req1_a, req1_b, cyc));
                    if (g >= 0) begin
                        lg_m = (g == 1);
                        busy = 1'b1;
                    end
                end else begin
                    chk("ready_busy", {30'h0, req0_ready, req1_ready}, 32'h0);
                end
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        chk("rsp_unexpected", {31'h0, rsp_valid}, 32'h0);
                    end else begin
                        e = q[0];
                        if (!in_resp) chk("rsp_latency", cyc, e.due);
                        chk("rsp_id", {31'h0, rsp_id}, {31'h0, e.id});
                        chk("rsp_result", {16'h0, rsp_result}, {16'h0, e.res});
                        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                        chk("flags_rsp", {28'h0, flags}, {28'h0, e.fl});
                        in_resp = 1'b1;
                        if (rsp_ready) begin
                            void'(q.pop_front());
                            busy    = 1'b0;
                            in_resp = 1'b0;
                        end
                    end
                end else if (q.size() > 0 && cyc >= q[0].due) begin
                    chk("rsp_late", {31'h0, rsp_valid}, 32'h1);
                    void'(q.pop_front());
                    busy    = 1'b0;
                    in_resp = 1'b0;
                end
            end
        end
    end

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Present one request and hold it until accepted; returns at the following negedge.
    task automatic send(input int p, input logic [5:0] op, input logic [15:0] a,
                        input logic [15:0] b);
        bit done;
        done = 1'b0;
        @(negedge clk);
        idle_inputs();
        if (p == 0) begin
            req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            #2;
            if ((p == 0) ? req0_ready : req1_ready) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) chk("send_timeout", {31'h0, done}, 32'h1);
        @(negedge clk);
        idle_inputs();
    endtask

    function automatic logic [5:0] rand_op();
        int r;
        r = $urandom_range(0, 99);
        if (r < 8) return 6'($urandom_range(25, 63));
        if (r < 30) return 6'($urandom_range(2, 4));
        return 6'($urandom_range(0, 24));
    endfunction

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        idle_inputs();
        req0_opcode = 6'h0; req0_a = 16'h0; req0_b = 16'h0;
        req1_opcode = 6'h0; req1_a = 16'h0; req1_b = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        send(0, 6'h00, 16'h7FFF, 16'h0001);
        repeat (3) @(negedge clk);

        // Both ports valid every cycle: grants must alternate.
        @(negedge clk);
        req0_valid = 1'b1; req0_opcode = 6'h0D; req0_b = 16'h1111;
        req1_valid = 1'b1; req1_opcode = 6'h0D; req1_b = 16'h2222;
        repeat (14) @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);

        send(0, 6'h01, 16'd5, 16'd5);
        send(1, 6'h12, 16'h1234, 16'h5678);
        send(0, 6'h00, 16'd1, 16'd1);
        send(1, 6'h12, 16'h0, 16'h0);
        send(0, 6'h03, 16'd9, 16'd0);
        send(1, 6'h20, 16'h00AA, 16'h0055);
        repeat (3) @(negedge clk);

        // Hold the response for several cycles while port 1 keeps requesting.
        rsp_ready = 1'b0;
        send(0, 6'h07, 16'hF0F0, 16'h0FF0);
        req1_valid = 1'b1; req1_opcode = 6'h05; req1_a = 16'hABCD; req1_b = 16'h00FF;
        repeat (8) @(negedge clk);
        rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        idle_inputs();

        // Reset in the middle of a multiply, then a tie must go to port 0.
        send(0, 6'h02, 16'h0123, 16'h0045);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_opcode = 6'h0D; req0_b = 16'h1111;
        req1_valid = 1'b1; req1_opcode = 6'h0D; req1_b = 16'h2222;
        @(negedge clk);
        idle_inputs();
        repeat (4) @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            req0_valid  = ($urandom_range(0, 2) != 0);
            req1_valid  = ($urandom_range(0, 2) != 0);
            req0_opcode = rand_op();
            req1_opcode = rand_op();
            req0_a      = 16'($urandom());
            req1_a      = 16'($urandom());
            req0_b      = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom());
            req1_b      = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom());
            rsp_ready   = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        idle_inputs();
        repeat (20) @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
